step_dir_decoder: RTL
=====================

Name: step_dir_decoder

Overview:
Receiver side of the step/direction interface used by the stepper drivers. It samples an external STEP/DIR pair, for example loopback from a driver or a host motion card. It filters glitches, tracks the signed axis position, measures the step period, and flags direction-setup violations. It sits between the board pins and the position/status register bank.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each input synchronizer (>=2)
FILTER_CYCLES, 4, consecutive stable cycles required before a filtered level changes (>=1)
DIR_SETUP, 2, minimum cycles filtered DIR must be stable before a filtered STEP rising edge
IDLE_TIMEOUT, 1000000, cycles without a step rising edge before MOVING returns to IDLE
CNT_W, 32, width of position and period

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
step_in  in  1  asynchronous STEP pin
dir_in  in  1  asynchronous DIR pin; 1 = negative direction
count_enable  in  1  1 = steps update position
pos_load  in  1  one-cycle strobe; load position
pos_load_val  in  CNT_W  value loaded on pos_load
err_clr  in  1  one-cycle strobe; clears dir_err
position  out  CNT_W  signed two's-complement axis position
step_strobe  out  1  one-cycle pulse per accepted step
step_dir  out  1  direction of the last accepted step
busy  out  1  1 while in state MOVING
dir_err  out  1  sticky direction-setup violation flag
period  out  CNT_W  cycles between the last two step rising edges
period_valid  out  1  one-cycle pulse when period updates

Behaviour:
- Reset: the clock and reset are fixed as one clock, clk, with reset rst synchronous and active-high.
  - All outputs go to 0 on reset.
  - Synchronizers, filtered levels and counters go to 0.
  - The state goes to IDLE.
  - Reset mid-operation discards any step in flight.
  - If step_in is held high through reset release, it produces one step after the filter delay.
- Input path: step_in and dir_in each pass through an independent SYNC_STAGES synchronizer and then a filter.
  - A filtered level changes only after the synchronized input has differed from it for FILTER_CYCLES consecutive cycles.
  - A shorter pulse is ignored and restarts the count.
- Step detect: a step is a rising edge of filtered STEP.
  - step_strobe is high exactly SYNC_STAGES+FILTER_CYCLES+1 cycles after the first clk edge that samples step_in high. With defaults this is 7 cycles.
  - The falling edge has no effect.
- Direction: step_dir is set to filtered DIR on each step.
  - dir_age counts cycles since the last filtered DIR change and saturates at DIR_SETUP.
  - If a step occurs with dir_age < DIR_SETUP, dir_err is set. The step is still counted using the current filtered DIR.
  - dir_err stays set until err_clr or rst. If err_clr and a violation occur in the same cycle, dir_err stays 1.
- Position: on a step with count_enable=1, position increments when DIR=0 and decrements when DIR=1.
  - Arithmetic is modulo 2^CNT_W. 0x7FFFFFFF+1 wraps to 0x80000000, and 0-1 gives 0xFFFFFFFF.
  - With count_enable=0, position holds, but step_strobe, step_dir, period and busy still update.
  - pos_load takes effect in the next cycle. If pos_load and a counted step coincide, position = pos_load_val ±1.
- State machine: IDLE -> MOVING on a step.
  - In MOVING, an idle counter is cleared on every step.
  - MOVING -> IDLE when the idle counter reaches IDLE_TIMEOUT-1 with no step.
  - A step in that same cycle keeps the state MOVING.
  - busy = (state == MOVING).
- Period: a period counter restarts at 1 on each step and saturates at all-ones.
  - On a step while in MOVING, period takes the counter value and period_valid pulses in the same cycle as step_strobe.
  - The first step out of IDLE loads no period.
  - period holds its value across IDLE.

Optional Feature:
STEP_DIR_DECODER_PERIOD_EN
- Defined: the period counter, period and period_valid are implemented as above.
- Undefined: the counter is removed, and period and period_valid are tied to 0. The idle timeout and all other behaviour are unchanged.

Decomposition:
- Shared package holds:
  - the state enum {IDLE, MOVING}
  - the constant CNT_W default
  - the DIR encoding constants DIR_POS=0 and DIR_NEG=1, shared with the stepper drivers
- Natural sub-module: step_dir_sig_filter (synchronizer plus stability filter, parameters SYNC_STAGES and FILTER_CYCLES), instantiated once for STEP and once for DIR.

Test Plan:
- Sanity stepping: 10 STEP pulses (high 8, low 8 cycles) with DIR=0 from reset -> position=10, 10 strobes, step_dir=0, busy=1, first strobe 7 cycles after the first high sample.
- Glitch rejection: 3-cycle high glitch on step_in -> no strobe, position unchanged. A 4-cycle pulse is accepted.
- Direction and wrap: pos_load 0x00000001, then 3 steps with DIR=1 -> position 0xFFFFFFFE. Load 0x7FFFFFFF, then 1 step with DIR=0 -> 0x80000000.
- Setup violation: toggle DIR so that filtered DIR changes 1 cycle before a filtered STEP rise -> dir_err=1 and the step is counted with the new DIR. err_clr -> dir_err=0.
- Period and idle: steps every 100 cycles -> the first step has no period_valid, later steps give period=100. Stop stepping -> busy falls exactly IDLE_TIMEOUT cycles after the last strobe (IDLE_TIMEOUT=50 in the bench).
- Simultaneous and reset: pos_load 0x100 in the same cycle as a counted DIR=0 step -> 0x101. count_enable=0 with 5 steps -> position held, 5 strobes. Assert rst mid-train -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/step_dir_decoder_pkg.sv
// Shared definitions for the step/direction receiver.
//   state_t   : decoder state (IDLE, MOVING)
//   CNT_W_DEF : default width of position and period
//   DIR_POS / DIR_NEG : DIR pin encoding, shared with the stepper drivers
package step_dir_decoder_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } state_t;

  localparam int   CNT_W_DEF = 32;
  localparam logic DIR_POS   = 1'b0;
  localparam logic DIR_NEG   = 1'b1;

endpackage

// File: rtl/step_dir_sig_filter.sv
// Synchronizer plus stability filter for one asynchronous pin.
// The filtered level changes only after the synchronized input has differed
// from it for FILTER_CYCLES consecutive cycles; shorter pulses are dropped.
// Ports:
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset
//   i_sig   : asynchronous input pin
//   o_level : filtered level
module step_dir_sig_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_level
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
      // Any sample agreeing with the current level restarts the count.
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_CYCLES - 1)) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/direction receiver: filters the STEP/DIR pins, tracks signed position,
// measures step period and flags direction-setup violations.
//
// Optional feature macro: STEP_DIR_DECODER_PERIOD_EN
//   defined   -> period counter, o_period and o_period_valid implemented
//   undefined -> o_period and o_period_valid tied to 0
//
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_step_in, i_dir_in   : asynchronous STEP / DIR pins (DIR 1 = negative)
//   i_count_enable        : steps update position when 1
//   i_pos_load/_val       : one-cycle strobe loading position
//   i_err_clr             : one-cycle strobe clearing o_dir_err
//   o_position            : signed axis position
//   o_step_strobe         : one-cycle pulse per accepted step
//   o_step_dir            : direction of last accepted step
//   o_busy                : 1 while MOVING
//   o_dir_err             : sticky direction-setup violation
//   o_period/_valid       : cycles between the last two steps, update pulse
//
// state  | meaning
// IDLE   | no step seen within IDLE_TIMEOUT cycles
// MOVING | steps arriving; idle counter running between them
module step_dir_decoder
  import step_dir_decoder_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int DIR_SETUP     = 2,
  parameter int IDLE_TIMEOUT  = 1000000,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_step_in,
  input  logic             i_dir_in,
  input  logic             i_count_enable,
  input  logic             i_pos_load,
  input  logic [CNT_W-1:0] i_pos_load_val,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_position,
  output logic             o_step_strobe,
  output logic             o_step_dir,
  output logic             o_busy,
  output logic             o_dir_err,
  output logic [CNT_W-1:0] o_period,
  output logic             o_period_valid
);

  localparam int AGE_W  = (DIR_SETUP > 0) ? $clog2(DIR_SETUP + 1) : 1;
  localparam int IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  logic w_step_filt, w_dir_filt;

  step_dir_sig_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_step_filt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_step_in),
    .o_level(w_step_filt)
  );

  step_dir_sig_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_dir_filt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_sig  (i_dir_in),
    .o_level(w_dir_filt)
  );

  // Both filtered levels pass through one aligned register stage so that the
  // strobe lands SYNC_STAGES+FILTER_CYCLES+1 cycles after the first sample
  // and STEP/DIR keep their relative timing for the setup check.
  logic r_step_q, r_step_q2, r_dir_q, r_dir_q2;
  logic w_step, w_dir_chg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_step_q  <= 1'b0;
      r_step_q2 <= 1'b0;
      r_dir_q   <= 1'b0;
      r_dir_q2  <= 1'b0;
    end else begin
      r_step_q  <= w_step_filt;
      r_step_q2 <= r_step_q;
      r_dir_q   <= w_dir_filt;
      r_dir_q2  <= r_dir_q;
    end
  end

  assign w_step    = r_step_q & ~r_step_q2;
  assign w_dir_chg = r_dir_q ^ r_dir_q2;

  // dir age: cycles the current filtered DIR has been stable, 0 in the cycle
  // it changes, saturating at DIR_SETUP.
  logic [AGE_W-1:0] r_dir_age, w_dir_age;
  logic             w_viol;

  assign w_dir_age = w_dir_chg ? '0 : r_dir_age;
  assign w_viol    = w_step && (w_dir_age < AGE_W'(DIR_SETUP));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dir_age <= '0;
    end else if (w_dir_age < AGE_W'(DIR_SETUP)) begin
      r_dir_age <= w_dir_age + AGE_W'(1);
    end else begin
      r_dir_age <= w_dir_age;
    end
  end

  // State machine
  state_t            r_state, w_state_nxt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_idle_done;

  assign w_idle_done = (r_idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_step) w_state_nxt = ST_MOVING;
      ST_MOVING: if (!w_step && w_idle_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_step || (r_state != ST_MOVING) || w_idle_done) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end

  // Position, strobe, direction, error flag
  logic [CNT_W-1:0] r_position, w_pos_base, w_pos_nxt;
  logic             r_step_strobe, r_step_dir, r_dir_err;

  always_comb begin
    w_pos_base = i_pos_load ? i_pos_load_val : r_position;
    w_pos_nxt  = w_pos_base;
    if (w_step && i_count_enable) begin
      w_pos_nxt = (r_dir_q == DIR_NEG) ? (w_pos_base - CNT_W'(1))
                                       : (w_pos_base + CNT_W'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_position    <= '0;
      r_step_strobe <= 1'b0;
      r_step_dir    <= 1'b0;
      r_dir_err     <= 1'b0;
    end else begin
      r_position    <= w_pos_nxt;
      r_step_strobe <= w_step;
      if (w_step) r_step_dir <= r_dir_q;
      // A violation in the same cycle as err_clr wins.
      r_dir_err <= (r_dir_err & ~i_err_clr) | w_viol;
    end
  end

  assign o_position    = r_position;
  assign o_step_strobe = r_step_strobe;
  assign o_step_dir    = r_step_dir;
  assign o_dir_err     = r_dir_err;
  assign o_busy        = (r_state == ST_MOVING);

`ifdef STEP_DIR_DECODER_PERIOD_EN
  logic [CNT_W-1:0] r_per_cnt, r_period;
  logic             r_period_valid;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_per_cnt      <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      r_period_valid <= 1'b0;
      if (w_step) begin
        r_per_cnt <= CNT_W'(1);
        // First step out of IDLE has no meaningful predecessor.
        if (r_state == ST_MOVING) begin
          r_period       <= r_per_cnt;
          r_period_valid <= 1'b1;
        end
      end else if (r_per_cnt != '1) begin
        r_per_cnt <= r_per_cnt + CNT_W'(1);
      end
    end
  end

  assign o_period       = r_period;
  assign o_period_valid = r_period_valid;
`else
  assign o_period       = '0;
  assign o_period_valid = 1'b0;
`endif

endmodule
